// File: rtl/debounce_pkg.sv
// Shared timing helpers and default parameters for front-panel button logic.
// Cycle counts are derived in integer arithmetic so they elaborate as constants.
package debounce_pkg;

   localparam int DEFAULT_CLK_FREQ_MHZ   = 150;
   localparam int DEFAULT_GLITCH_TIME_NS = 100;
   localparam int DEFAULT_SYNC_STAGES    = 3;
   localparam int DEFAULT_LONG_PRESS_MS  = 500;

   // Ceiling of freq*ns/1000, never below one cycle.
   function automatic int cycles_from_ns(input int freq_mhz, input int ns);
      int c;
      c = (freq_mhz * ns + 999) / 1000;
      if (c < 1) c = 1;
      return c;
   endfunction

   function automatic int cycles_from_ms(input int freq_mhz, input int ms);
      return freq_mhz * 1000 * ms;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One key channel: synchroniser, glitch filter, debounced level and strobes.
// Hold counter for long-press strobe exists only with MULTI_KEY_DEBOUNCER_LONG_PRESS_EN.
module debounce_channel #(
   parameter int GLITCH_CYCLES = 15,
   parameter int SYNC_STAGES   = 3,
   parameter int ACTIVE_LOW    = 1,
   parameter int LONG_CYCLES   = 75000000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic key_i,
   output logic pressed_o,
   output logic press_stb_o,
   output logic release_stb_o,
   output logic long_press_stb_o
);
   localparam int               CNT_W    = $clog2(GLITCH_CYCLES + 1);
   localparam logic             REL_LVL  = 1'(ACTIVE_LOW != 0);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GLITCH_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   pressed_q, pressed_d;
   logic                   press_q, press_d;
   logic                   release_q, release_d;
   logic                   raw_pressed;

   // Synchroniser presets to the released level so reset exit never looks like a press.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sync_q <= {SYNC_STAGES{REL_LVL}};
      else         sync_q <= {sync_q[SYNC_STAGES-2:0], key_i};
   end

   assign raw_pressed = sync_q[SYNC_STAGES-1] ^ REL_LVL;

   always_comb begin
      cnt_d     = cnt_q;
      pressed_d = pressed_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (raw_pressed == pressed_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d     = '0;
         pressed_d = raw_pressed;
         press_d   = raw_pressed;
         release_d = ~raw_pressed;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q     <= '0;
         pressed_q <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         pressed_q <= pressed_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign pressed_o     = pressed_q;
   assign press_stb_o   = press_q;
   assign release_stb_o = release_q;

`ifdef MULTI_KEY_DEBOUNCER_LONG_PRESS_EN
   localparam int                HOLD_W    = $clog2(LONG_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_CYCLES);

   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              long_q, long_d;

   // Parking at HOLD_SAT limits each press to a single long-press strobe.
   always_comb begin
      hold_d = hold_q;
      long_d = 1'b0;
      if (!pressed_q) begin
         hold_d = '0;
      end else if (hold_q == HOLD_LAST) begin
         hold_d = HOLD_SAT;
         long_d = 1'b1;
      end else if (hold_q != HOLD_SAT) begin
         hold_d = hold_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hold_q <= '0;
         long_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
         long_q <= long_d;
      end
   end

   assign long_press_stb_o = long_q;
`else
   // LONG_CYCLES stays in the parameter list so both builds share one interface; this is constant 0.
   assign long_press_stb_o = 1'(LONG_CYCLES < 0);
`endif

endmodule

// File: rtl/multi_key_debouncer.sv
// N independent key debouncers with press/release strobes; one instance per key group.
// Optional long-press strobe enabled by MULTI_KEY_DEBOUNCER_LONG_PRESS_EN.
module multi_key_debouncer
   import debounce_pkg::*;
#(
   parameter int CLK_FREQ_MHZ   = DEFAULT_CLK_FREQ_MHZ,
   parameter int GLITCH_TIME_NS = DEFAULT_GLITCH_TIME_NS,
   parameter int CHANNELS       = 4,
   parameter int ACTIVE_LOW     = 1,
   parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES,
   parameter int LONG_PRESS_MS  = DEFAULT_LONG_PRESS_MS
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [CHANNELS-1:0] key_i,
   output logic [CHANNELS-1:0] pressed_o,
   output logic [CHANNELS-1:0] press_stb_o,
   output logic [CHANNELS-1:0] release_stb_o,
   output logic [CHANNELS-1:0] long_press_stb_o
);
   localparam int GLITCH_CYCLES = cycles_from_ns(CLK_FREQ_MHZ, GLITCH_TIME_NS);
   localparam int LONG_CYCLES   = cycles_from_ms(CLK_FREQ_MHZ, LONG_PRESS_MS);

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      debounce_channel #(
         .GLITCH_CYCLES (GLITCH_CYCLES),
         .SYNC_STAGES   (SYNC_STAGES),
         .ACTIVE_LOW    (ACTIVE_LOW),
         .LONG_CYCLES   (LONG_CYCLES)
      ) u_ch (
         .clk_i            (clk_i),
         .rst_ni           (rst_ni),
         .key_i            (key_i[g]),
         .pressed_o        (pressed_o[g]),
         .press_stb_o      (press_stb_o[g]),
         .release_stb_o    (release_stb_o[g]),
         .long_press_stb_o (long_press_stb_o[g])
      );
   end

endmodule

// File: tb/tb_multi_key_debouncer.sv
// Directed bench for multi_key_debouncer at 10 MHz / 500 ns (5 glitch cycles, 8-cycle latency).
// Long-press scenarios run when MULTI_KEY_DEBOUNCER_LONG_PRESS_EN is defined.
module tb_multi_key_debouncer;
   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic [3:0] key_i;
   logic [3:0] pressed_o, press_stb_o, release_stb_o, long_press_stb_o;

   int errors = 0;
   int checks = 0;

   multi_key_debouncer #(
      .CLK_FREQ_MHZ   (10),
      .GLITCH_TIME_NS (500),
      .CHANNELS       (4),
      .ACTIVE_LOW     (1),
      .SYNC_STAGES    (3),
      .LONG_PRESS_MS  (1)
   ) dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .key_i            (key_i),
      .pressed_o        (pressed_o),
      .press_stb_o      (press_stb_o),
      .release_stb_o    (release_stb_o),
      .long_press_stb_o (long_press_stb_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      rst_ni = 1'b1;
      key_i  = 4'b1111;
      #2 rst_ni = 1'b0;
      #1;
      checks++;
      if ({pressed_o, press_stb_o, release_stb_o, long_press_stb_o} !== 16'h0) begin
         errors++;
         $display("FAIL reset_outputs: got %h want 0000", {pressed_o, press_stb_o, release_stb_o, long_press_stb_o});
      end
      tick(); tick();
      rst_ni = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         checks++;
         if ({pressed_o, press_stb_o, release_stb_o} !== 12'h0) begin
            errors++;
            $display("FAIL reset_exit c%0d: pressed=%b press=%b release=%b want all 0", i, pressed_o, press_stb_o, release_stb_o);
         end
      end
   endtask

   task automatic test_clean_press();
      key_i[0] = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         logic [3:0] exp_p, exp_s;
         tick();
         exp_p = (i >= 8) ? 4'b0001 : 4'b0000;
         exp_s = (i == 8) ? 4'b0001 : 4'b0000;
         checks++;
         if (pressed_o !== exp_p || press_stb_o !== exp_s || release_stb_o !== 4'b0000) begin
            errors++;
            $display("FAIL clean_press c%0d: pressed=%b press=%b release=%b want %b %b 0000",
                     i, pressed_o, press_stb_o, release_stb_o, exp_p, exp_s);
         end
      end
   endtask

   task automatic test_bounce();
      logic levels [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      int   lens   [4] = '{4, 2, 4, 12};
      int   pulses = 0;
      int   at = 0;
      for (int s = 0; s < 4; s++) begin
         key_i[1] = levels[s];
         for (int i = 0; i < lens[s]; i++) begin
            tick();
            checks++;
            if (pressed_o[1] !== 1'b0 || press_stb_o[1] !== 1'b0 || release_stb_o[1] !== 1'b0) begin
               errors++;
               $display("FAIL bounce_filter seg%0d c%0d: pressed=%b press=%b release=%b want 0 0 0",
                        s, i, pressed_o[1], press_stb_o[1], release_stb_o[1]);
            end
         end
      end
      key_i[1] = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (press_stb_o[1] === 1'b1) begin
            pulses++;
            at = i;
         end
      end
      checks++;
      if (pulses != 1 || at != 8) begin
         errors++;
         $display("FAIL bounce_settle: pulses=%0d at=%0d want 1 at 8", pulses, at);
      end
      checks++;
      if (pressed_o[1] !== 1'b1) begin
         errors++;
         $display("FAIL bounce_level: pressed[1]=%b want 1", pressed_o[1]);
      end
      key_i[1] = 1'b1;
      repeat (12) tick();
   endtask

   task automatic test_release();
      key_i[0] = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         logic exp_p, exp_r;
         tick();
         exp_p = (i < 8);
         exp_r = (i == 8);
         checks++;
         if (pressed_o[0] !== exp_p || release_stb_o[0] !== exp_r || press_stb_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL release c%0d: pressed=%b release=%b press=%b want %b %b 0",
                     i, pressed_o[0], release_stb_o[0], press_stb_o[0], exp_p, exp_r);
         end
      end
   endtask

   task automatic test_simultaneous();
      key_i = 4'b0000;
      for (int i = 1; i <= 10; i++) begin
         logic [3:0] exp_s;
         tick();
         exp_s = (i == 8) ? 4'b1111 : 4'b0000;
         checks++;
         if (press_stb_o !== exp_s || release_stb_o !== 4'b0000) begin
            errors++;
            $display("FAIL simultaneous c%0d: press=%b release=%b want %b 0000", i, press_stb_o, release_stb_o, exp_s);
         end
      end
      key_i = 4'b1111;
      for (int i = 1; i <= 10; i++) begin
         logic [3:0] exp_r;
         tick();
         exp_r = (i == 8) ? 4'b1111 : 4'b0000;
         checks++;
         if (release_stb_o !== exp_r || press_stb_o !== 4'b0000) begin
            errors++;
            $display("FAIL simult_release c%0d: release=%b press=%b want %b 0000", i, release_stb_o, press_stb_o, exp_r);
         end
      end
      repeat (4) tick();
   endtask

   task automatic test_reset_mid();
      key_i[2] = 1'b0;
      repeat (10) tick();
      key_i[3] = 1'b0;
      repeat (6) tick();
      checks++;
      if (pressed_o !== 4'b0100) begin
         errors++;
         $display("FAIL pre_reset_state: pressed=%b want 0100", pressed_o);
      end
      #2 rst_ni = 1'b0;
      #1;
      checks++;
      if ({pressed_o, press_stb_o, release_stb_o, long_press_stb_o} !== 16'h0) begin
         errors++;
         $display("FAIL async_reset: pressed=%b press=%b release=%b long=%b want all 0",
                  pressed_o, press_stb_o, release_stb_o, long_press_stb_o);
      end
      key_i = 4'b1111;
      tick(); tick();
      rst_ni = 1'b1;
      for (int i = 1; i <= 50; i++) begin
         tick();
         checks++;
         if ({pressed_o, press_stb_o, release_stb_o} !== 12'h0) begin
            errors++;
            $display("FAIL post_reset c%0d: pressed=%b press=%b release=%b want all 0",
                     i, pressed_o, press_stb_o, release_stb_o);
         end
      end
   endtask

`ifdef MULTI_KEY_DEBOUNCER_LONG_PRESS_EN
   task automatic test_long_press();
      int pulses, at, wait_cnt;
      bit seen;
      // 15000-cycle hold: one strobe exactly 10000 cycles after the press strobe.
      key_i[0] = 1'b0;
      seen = 0;
      wait_cnt = 0;
      while (!seen && wait_cnt < 20) begin
         tick();
         wait_cnt++;
         seen = (press_stb_o[0] === 1'b1);
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL long_press_start: no press strobe within 20 cycles");
      end
      pulses = 0;
      at = 0;
      for (int i = 1; i <= 15000; i++) begin
         tick();
         if (long_press_stb_o[0] === 1'b1) begin
            pulses++;
            at = i;
         end
      end
      checks++;
      if (pulses != 1 || at != 10000) begin
         errors++;
         $display("FAIL long_press: pulses=%0d at=%0d want 1 at 10000", pulses, at);
      end
      key_i[0] = 1'b1;
      repeat (12) tick();
      // 9000-cycle hold: no long-press strobe.
      pulses = 0;
      key_i[0] = 1'b0;
      for (int i = 1; i <= 9000; i++) begin
         tick();
         if (long_press_stb_o[0] === 1'b1) pulses++;
      end
      key_i[0] = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (long_press_stb_o[0] === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL short_hold: long pulses=%0d want 0", pulses);
      end
   endtask
`else
   task automatic test_long_press();
      int pulses = 0;
      key_i[0] = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (long_press_stb_o !== 4'b0000) pulses++;
      end
      key_i[0] = 1'b1;
      repeat (12) tick();
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL long_press_off: nonzero long strobe cycles=%0d want 0", pulses);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_release();
      test_simultaneous();
      test_reset_mid();
      test_long_press();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
